// File: rtl/pwm_pkg.sv
// Shared definitions for the multichannel PWM block: register map
// addresses and the address-width helper used by the top-level port list.
package pwm_pkg;

    // Register map. Channel i's duty register sits at ADDR_DUTY0 + i.
    localparam int ADDR_EN    = 0;
    localparam int ADDR_PRESC = 1;
    localparam int ADDR_TOP   = 2;
    localparam int ADDR_DUTY0 = 3;

    // Number of mapped registers for a given channel count.
    function automatic int num_regs(input int num_ch);
        return num_ch + ADDR_DUTY0;
    endfunction

    // Width of the write address bus: enough bits to reach every mapped
    // register (EN, PRESC, TOP and one DUTY per channel).
    function automatic int addr_w(input int num_ch);
        return $clog2(num_regs(num_ch));
    endfunction

endpackage : pwm_pkg

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: gated duty compare against the shared period counter,
// followed by the output flop so every pwm_out bit is glitch-free.
module pwm_channel_cmp #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             pwm_o
);

    logic pwm_d;
    logic pwm_q;

    // Output is high while the counter is below the duty value. Duty 0
    // never matches (constant low); duty above TOP always matches
    // (constant high). A disabled channel is forced low.
    always_comb begin
        pwm_d = en_i && (cnt_i < duty_i);
    end

    // Register the compare result; asynchronous reset clears the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule : pwm_channel_cmp

// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator. A register file (EN, PRESC, TOP, DUTY[i])
// is written through a valid/ready port. PRESC, TOP and DUTY writes land in
// staging copies and are transferred to the active copies only at the end
// of a period (the commit cycle), so a running waveform never sees a
// half-updated configuration. EN takes effect immediately.
//
// Write handshake: a write is accepted on a rising edge where
// wr_valid && wr_ready. wr_ready is low only in the commit cycle, so a
// staging register is never written in the same cycle it is copied to
// the active set; the master keeps wr_valid, wr_addr and wr_data stable
// until the write is accepted. Writes to unmapped addresses are accepted,
// discarded, and flagged by a one-cycle wr_err pulse on the next cycle.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = 8,
    parameter  int PRESC_W = 8,
    localparam int ADDR_W  = addr_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    output logic              wr_err,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [ADDR_W:0] NUM_REGS = (ADDR_W + 1)'(num_regs(NUM_CH));

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]  en_q,        en_d;
    logic [PRESC_W-1:0] presc_stg_q, presc_stg_d;
    logic [PRESC_W-1:0] presc_act_q, presc_act_d;
    logic [CNT_W-1:0]   top_stg_q,   top_stg_d;
    logic [CNT_W-1:0]   top_act_q,   top_act_d;
    logic [CNT_W-1:0]   duty_stg_q [NUM_CH];
    logic [CNT_W-1:0]   duty_stg_d [NUM_CH];
    logic [CNT_W-1:0]   duty_act_q [NUM_CH];
    logic [CNT_W-1:0]   duty_act_d [NUM_CH];
    logic               wr_err_q,    wr_err_d;

    // ------------------------------------------------------------------
    // Timebase state
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               presc_tick;
    logic               commit;
    logic               all_off;
    logic               load_act;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic               wr_fire;
    logic               addr_mapped;
    logic               sel_en;
    logic               sel_presc;
    logic               sel_top;
    logic [NUM_CH-1:0]  sel_duty;
    logic [PRESC_W-1:0] presc_wdata;

    assign wr_fire     = wr_valid && wr_ready;
    assign addr_mapped = ({1'b0, wr_addr} < NUM_REGS);
    assign sel_en      = wr_fire && (wr_addr == ADDR_W'(ADDR_EN));
    assign sel_presc   = wr_fire && (wr_addr == ADDR_W'(ADDR_PRESC));
    assign sel_top     = wr_fire && (wr_addr == ADDR_W'(ADDR_TOP));

    // One select line per duty register.
    always_comb begin
        sel_duty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_duty[i] = wr_fire && (wr_addr == ADDR_W'(ADDR_DUTY0 + i));
        end
    end

    // Prescaler write data: low PRESC_W bits of wr_data, zero-extended
    // when the prescaler is wider than the data bus.
    if (PRESC_W > CNT_W) begin : g_presc_ext
        assign presc_wdata = {{(PRESC_W - CNT_W){1'b0}}, wr_data};
    end else begin : g_presc_trunc
        assign presc_wdata = wr_data[PRESC_W-1:0];
    end

    // ------------------------------------------------------------------
    // Timebase: prescaler counts 0..PRESC_act, each wrap advances the
    // period counter 0..TOP_act; the wrap at TOP_act is the commit cycle.
    // With every channel disabled both counters hold at zero so enabling
    // a channel always starts a fresh period.
    // ------------------------------------------------------------------
    assign all_off = (en_q == '0);

    // Next-state for prescaler and period counter, plus tick/commit strobes.
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        cnt_d       = cnt_q;
        presc_tick  = 1'b0;
        commit      = 1'b0;
        if (all_off) begin
            presc_cnt_d = '0;
            cnt_d       = '0;
        end else if (presc_cnt_q == presc_act_q) begin
            presc_cnt_d = '0;
            presc_tick  = 1'b1;
            if (cnt_q == top_act_q) begin
                cnt_d  = '0;
                commit = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        end
    end

    // Timebase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
            cnt_q       <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
        end
    end

    // Active copies follow staging at each commit, and continuously while
    // everything is disabled so a later enable starts with fresh values.
    assign load_act = commit || all_off;

    // ------------------------------------------------------------------
    // Register file next-state: staging writes, active transfer, wr_err.
    // ------------------------------------------------------------------
    always_comb begin
        en_d        = en_q;
        presc_stg_d = presc_stg_q;
        top_stg_d   = top_stg_q;
        duty_stg_d  = duty_stg_q;
        presc_act_d = presc_act_q;
        top_act_d   = top_act_q;
        duty_act_d  = duty_act_q;
        wr_err_d    = wr_fire && !addr_mapped;

        if (sel_en) begin
            en_d = wr_data[NUM_CH-1:0];
        end
        if (sel_presc) begin
            presc_stg_d = presc_wdata;
        end
        if (sel_top) begin
            top_stg_d = wr_data;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_duty[i]) begin
                duty_stg_d[i] = wr_data;
            end
        end

        // Writes are blocked during commit, so the staging values read here
        // are never the ones being written in the same cycle.
        if (load_act) begin
            presc_act_d = presc_stg_q;
            top_act_d   = top_stg_q;
            duty_act_d  = duty_stg_q;
        end
    end

    // Register file flops; TOP resets to all-ones, everything else to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= '0;
            presc_stg_q <= '0;
            presc_act_q <= '0;
            top_stg_q   <= '1;
            top_act_q   <= '1;
            wr_err_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_stg_q[i] <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            en_q        <= en_d;
            presc_stg_q <= presc_stg_d;
            presc_act_q <= presc_act_d;
            top_stg_q   <= top_stg_d;
            top_act_q   <= top_act_d;
            wr_err_q    <= wr_err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_stg_q[i] <= duty_stg_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel_cmp #(
            .CNT_W (CNT_W)
        ) u_cmp (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en_q[g]),
            .cnt_i  (cnt_q),
            .duty_i (duty_act_q[g]),
            .pwm_o  (pwm_out[g])
        );
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_ready    = !commit;
    assign period_tick = commit;
    assign wr_err      = wr_err_q;

endmodule : pwm_multichannel
